// File: rtl/brew_sequencer.sv
// Coffee machine drink-cycle controller: CHECK, then timed HEAT/DOSE/POUR
// phases from a prescaled tick, with sensor-loss aborts into FAULT.
module brew_sequencer #(
  parameter int         TICK_DIV = 50_000_000,
  parameter logic [7:0] HEAT_T   = 8'd5,
  parameter logic [7:0] DOSE_T   = 8'd2,
  parameter logic [7:0] POUR_S   = 8'd3,
  parameter logic [7:0] POUR_M   = 8'd5,
  parameter logic [7:0] POUR_L   = 8'd8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       A,
  input  logic       VL,
  input  logic [1:0] SEL,
  input  logic       SR,
  input  logic       SP,
  input  logic       SN,
  output logic       AQ,
  output logic       PP,
  output logic       P,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] ERR,
  output logic [2:0] ST
);

  localparam int PW = $clog2(TICK_DIV) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_HEAT   = 3'd2,
    S_DOSE   = 3'd3,
    S_POUR   = 3'd4,
    S_FINISH = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t          r_state, w_nxt;
  logic [1:0]      r_err, w_err_nxt;
  logic [1:0]      r_size;
  logic            r_a_q;
  logic [PW-1:0]   r_pre;
  logic [7:0]      r_tmr;
  logic [7:0]      w_dur;
  logic            w_tick, w_start, w_done;

  assign w_start = A & ~r_a_q;
  assign w_tick  = (r_pre == PW'(TICK_DIV - 1));
  assign w_done  = w_tick && (r_tmr == w_dur - 8'd1);

  always_comb begin
    w_dur = HEAT_T;
    case (r_state)
      S_DOSE: w_dur = DOSE_T;
      S_POUR: begin
        case (r_size)
          2'b01:   w_dur = POUR_S;
          2'b10:   w_dur = POUR_M;
          default: w_dur = POUR_L;
        endcase
      end
      default: w_dur = HEAT_T;
    endcase
  end

  // Water loss outranks cup loss; aborts outrank phase completion.
  always_comb begin
    w_nxt     = r_state;
    w_err_nxt = r_err;
    case (r_state)
      S_IDLE:
        if (w_start && VL && SEL != 2'b00) w_nxt = S_CHECK;
      S_CHECK:
        if (SR && SP && SN) w_nxt = S_HEAT;
        else begin
          w_nxt     = S_FAULT;
          w_err_nxt = !SR ? 2'b01 : (!SP ? 2'b10 : 2'b11);
        end
      S_HEAT, S_DOSE, S_POUR:
        if (r_state != S_DOSE && !SR) begin
          w_nxt     = S_FAULT;
          w_err_nxt = 2'b01;
        end else if (!SN) begin
          w_nxt     = S_FAULT;
          w_err_nxt = 2'b11;
        end else if (w_done) begin
          w_nxt = (r_state == S_HEAT) ? S_DOSE :
                  (r_state == S_DOSE) ? S_POUR : S_FINISH;
        end
      S_FINISH:
        w_nxt = S_IDLE;
      S_FAULT:
        if (w_start) begin
          w_nxt     = S_IDLE;
          w_err_nxt = 2'b00;
        end
      default: begin
        w_nxt     = S_IDLE;
        w_err_nxt = 2'b00;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_err   <= 2'b00;
      r_a_q   <= 1'b1;
    end else begin
      r_state <= w_nxt;
      r_err   <= w_err_nxt;
      r_a_q   <= A;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pre  <= '0;
      r_tmr  <= 8'd0;
      r_size <= 2'b00;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_nxt != r_state)
        r_tmr <= 8'd0;
      else if (w_tick)
        r_tmr <= r_tmr + 8'd1;
      if (r_state == S_IDLE && w_nxt == S_CHECK)
        r_size <= SEL;
    end
  end

  assign ST   = r_state;
  assign AQ   = (r_state == S_HEAT);
  assign PP   = (r_state == S_DOSE);
  assign P    = (r_state == S_POUR);
  assign DONE = (r_state == S_FINISH);
  assign BUSY = (r_state != S_IDLE) && (r_state != S_FAULT);
  assign ERR  = (r_state == S_FAULT) ? r_err : 2'b00;

endmodule

// File: tb/tb_brew_sequencer.sv
// Bench for brew_sequencer at TICK_DIV=1: vector table, directed corner
// sequences and random stimulus against a phase/countdown reference model.
module tb_brew_sequencer;

  localparam int HEAT_T = 5, DOSE_T = 2, POUR_S = 3, POUR_M = 5, POUR_L = 8;

  logic       CLK = 1'b0;
  logic       RST, A, VL, SR, SP, SN;
  logic [1:0] SEL;
  logic       AQ, PP, P, BUSY, DONE;
  logic [1:0] ERR;
  logic [2:0] ST;

  brew_sequencer #(.TICK_DIV(1)) dut (
    .CLK(CLK), .RST(RST), .A(A), .VL(VL), .SEL(SEL),
    .SR(SR), .SP(SP), .SN(SN),
    .AQ(AQ), .PP(PP), .P(P), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .ST(ST)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: current phase, cycles left in it, captured size, fault code.
  int   m_st, m_left, m_size, m_err;
  logic m_aq;

  function automatic int pour_len(input int sz);
    return (sz == 1) ? POUR_S : (sz == 2) ? POUR_M : POUR_L;
  endfunction

  function automatic logic [9:0] dut_out();
    return {ST, AQ, PP, P, BUSY, DONE, ERR};
  endfunction

  function automatic logic [9:0] model_out();
    return {3'(m_st), m_st == 2, m_st == 3, m_st == 4,
            (m_st >= 1 && m_st <= 5), m_st == 5, 2'(m_err)};
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_left = 0; m_size = 0; m_err = 0; m_aq = 1'b1;
  endtask

  task automatic model_step(input logic a, vl, input logic [1:0] sel,
                            input logic sr, sp, sn);
    logic ev;
    ev   = a && !m_aq;
    m_aq = a;
    case (m_st)
      0: if (ev && vl && sel != 2'b00) begin m_size = int'(sel); m_st = 1; end
      1: if (sr && sp && sn) begin m_st = 2; m_left = HEAT_T; end
         else begin m_st = 6; m_err = !sr ? 1 : (!sp ? 2 : 3); end
      2, 3, 4: begin
        if (m_st != 3 && !sr) begin m_st = 6; m_err = 1; end
        else if (!sn) begin m_st = 6; m_err = 3; end
        else begin
          m_left--;
          if (m_left == 0) begin
            m_st++;
            m_left = (m_st == 3) ? DOSE_T : (m_st == 4) ? pour_len(m_size) : 0;
          end
        end
      end
      5: m_st = 0;
      6: if (ev) begin m_st = 0; m_err = 0; end
      default: m_st = 0;
    endcase
  endtask

  // One clock: drive, advance model, sample 1 time unit after the edge.
  task automatic cyc(input logic a, vl, input logic [1:0] sel,
                     input logic sr, sp, sn);
    A = a; VL = vl; SEL = sel; SR = sr; SP = sp; SN = sn;
    model_step(a, vl, sel, sr, sp, sn);
    @(posedge CLK);
    #1;
    chk("model", 16'(dut_out()), 16'(model_out()));
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #1;
    chk("reset_immediate", 16'(dut_out()), 16'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  task automatic wait_st(input logic [2:0] s, input logic a, vl,
                         input logic [1:0] sel, input logic sr, sp, sn);
    for (int i = 0; i < 40 && ST != s; i++) cyc(a, vl, sel, sr, sp, sn);
    chk("wait_state", 16'(ST), 16'(s));
  endtask

  typedef struct {
    logic       a, vl;
    logic [1:0] sel;
    logic       sr, sp, sn;
    logic [2:0] exp_st;
    logic       exp_busy;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vt[12];

  initial begin
    int c_aq, c_pp, c_p, c_busy, c_done;
    logic ra, rvl, rsr, rsp, rsn;
    logic [1:0] rsel;

    A = 0; VL = 0; SEL = 2'b00; SR = 1; SP = 1; SN = 1; RST = 1'b1;
    model_reset();
    #2;
    do_reset();

    // Invalid requests, held button, missing powder and its acknowledgment.
    vt[0]  = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 2'b00};
    vt[1]  = '{1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 2'b00};
    vt[2]  = '{1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 2'b00};
    vt[3]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 2'b00};
    vt[4]  = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 2'b00};
    vt[5]  = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 2'b00};
    vt[6]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 2'b00};
    vt[7]  = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 2'b00};
    vt[8]  = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 2'b10};
    vt[9]  = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 2'b10};
    vt[10] = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 2'b00};
    vt[11] = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 2'b00};
    for (int i = 0; i < 12; i++) begin
      cyc(vt[i].a, vt[i].vl, vt[i].sel, vt[i].sr, vt[i].sp, vt[i].sn);
      chk($sformatf("vec%0d", i), 16'(dut_out()),
          16'({vt[i].exp_st, 3'b000, vt[i].exp_busy, 1'b0, vt[i].exp_err}));
    end

    // Normal small cycle with exact phase lengths.
    cyc(1, 1, 2'b01, 1, 1, 1);
    chk("start_latency", 16'(ST), 16'd1);
    c_aq = 0; c_pp = 0; c_p = 0; c_done = 0; c_busy = int'(BUSY);
    for (int i = 0; i < 13; i++) begin
      cyc(0, 1, 2'b01, 1, 1, 1);
      if (i == 0) chk("heat_latency", 16'(ST), 16'd2);
      c_aq += int'(AQ); c_pp += int'(PP); c_p += int'(P);
      c_done += int'(DONE); c_busy += int'(BUSY);
    end
    chk("small_heat_len", 16'(c_aq), 16'(HEAT_T));
    chk("small_dose_len", 16'(c_pp), 16'(DOSE_T));
    chk("small_pour_len", 16'(c_p), 16'(POUR_S));
    chk("small_done_len", 16'(c_done), 16'd1);
    chk("small_busy_len", 16'(c_busy), 16'd12);
    chk("small_back_idle", 16'(ST), 16'd0);

    // Cup removed in the 4th cycle of a large POUR.
    cyc(1, 1, 2'b11, 1, 1, 1);
    wait_st(3'd4, 0, 1, 2'b11, 1, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 2'b11, 1, 1, 1);
    chk("cup_pour_before", 16'(P), 16'd1);
    cyc(0, 1, 2'b11, 1, 1, 0);
    chk("cup_lost", 16'({ST, P, ERR}), 16'({3'd6, 1'b0, 2'b11}));
    cyc(1, 1, 2'b11, 1, 1, 1);
    chk("cup_ack", 16'({ST, ERR}), 16'({3'd0, 2'b00}));
    cyc(0, 1, 2'b11, 1, 1, 1);

    // Water and cup lost together in HEAT.
    cyc(1, 1, 2'b01, 1, 1, 1);
    wait_st(3'd2, 0, 1, 2'b01, 1, 1, 1);
    cyc(0, 1, 2'b01, 0, 1, 0);
    chk("both_lost", 16'({ST, AQ, ERR}), 16'({3'd6, 1'b0, 2'b01}));
    cyc(1, 1, 2'b01, 1, 1, 1);
    cyc(0, 1, 2'b01, 1, 1, 1);

    // Selection changed during HEAT must not alter the large POUR length.
    cyc(1, 1, 2'b11, 1, 1, 1);
    wait_st(3'd2, 0, 1, 2'b11, 1, 1, 1);
    wait_st(3'd4, 0, 1, 2'b01, 1, 1, 1);
    c_p = int'(P);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 2'b01, 1, 1, 1);
      c_p += int'(P);
    end
    chk("sel_change_pour", 16'(c_p), 16'(POUR_L));

    // Reset mid-POUR with A held high.
    cyc(1, 1, 2'b10, 1, 1, 1);
    wait_st(3'd4, 1, 1, 2'b10, 1, 1, 1);
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 2'b10, 1, 1, 1);
      chk("held_after_reset", 16'(ST), 16'd0);
    end
    cyc(0, 1, 2'b10, 1, 1, 1);
    cyc(1, 1, 2'b10, 1, 1, 1);
    chk("restart_after_reset", 16'(ST), 16'd1);
    wait_st(3'd0, 0, 1, 2'b10, 1, 1, 1);

    // Random stimulus against the model.
    ra = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) ra = ~ra;
      rvl  = ($urandom_range(0, 7) != 0);
      rsel = 2'($urandom_range(0, 3));
      rsr  = ($urandom_range(0, 40) != 0);
      rsp  = ($urandom_range(0, 10) != 0);
      rsn  = ($urandom_range(0, 40) != 0);
      if ($urandom_range(0, 599) == 0) begin
        #2;
        do_reset();
      end
      cyc(ra, rvl, rsel, rsr, rsp, rsn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/brew_sequencer.md
# brew_sequencer

- Timed controller that runs one drink cycle on the coffee machine actuators: heater (AQ), powder doser (PP) and pump (P).
- Accepts a start request from the panel button when the drink selection is valid, then checks the sensors.
- Runs the HEAT, DOSE and POUR phases from a prescaled time base and aborts safely on sensor loss.
- Sits between the switch/validation logic and the actuator LEDs; exports a state code for the seven-segment decoder.

## Interface
- TICK_DIV, 50_000_000: CLK cycles per time-base tick (1 s at 50 MHz); must be ≥1.
- HEAT_T, 5: HEAT duration in ticks.
- DOSE_T, 2: DOSE duration in ticks.
- POUR_S / POUR_M / POUR_L, 3 / 5 / 8: POUR duration in ticks for small/medium/large.
- All durations are 8-bit values and must be ≥1.
- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- A  in  1  start/acknowledge button, level, active-high, already synchronous to CLK.
- VL  in  1  selection-valid flag from the switch validation logic.
- SEL  in  2  drink size {B1,B0}: 01 small, 10 medium, 11 large, 00 none.
- SR / SP / SN  in  1 each  water present / powder present / cup present; active-high.
- AQ, PP, P  out  1 each  heater, doser and pump enables.
- BUSY  out  1  high in any state other than IDLE and FAULT.
- DONE  out  1  one-cycle pulse at the end of a successful cycle.
- ERR  out  2  fault code: 00 none, 01 no water, 10 no powder, 11 no cup.
- ST  out  3  state code for the display decoder.

## Operation
- Moore machine; all outputs decode the registered state only.
- State codes: IDLE=0, CHECK=1, HEAT=2, DOSE=3, POUR=4, FINISH=5, FAULT=6.
- Output decode: AQ=1 only in HEAT; PP=1 only in DOSE; P=1 only in POUR; DONE=1 only in FINISH.
- Button edge: register a_q holds the previous A; start event = A & ~a_q.
- a_q resets to 1, so holding A through reset release produces no start.
- IDLE: on a start event with VL=1 and SEL≠00, capture SEL into the size register and go to CHECK.
  - Any other start event is ignored.
  - SEL changes after capture are ignored until the next IDLE.
- CHECK (exactly one cycle): if SR&SP&SN go to HEAT; otherwise go to FAULT.
  - ERR on this fault uses priority water (01) > powder (10) > cup (11).
- HEAT → DOSE → POUR → FINISH: each phase lasts its duration in ticks. POUR uses POUR_S/M/L according to the captured size.
- FINISH: one cycle, then IDLE.
- Aborts, evaluated every cycle in timed phases:
  - SR=0 in HEAT or POUR → FAULT with ERR=01.
  - SN=0 in HEAT, DOSE or POUR → FAULT with ERR=11.
  - If both occur together, ERR=01.
  - SP is checked only in CHECK.
  - An abort takes priority over phase completion in the same cycle.
- FAULT: all actuators stay off and ERR holds its code. A start event clears ERR to 00 and returns to IDLE; this acknowledgment does not start a new cycle.
- Start events in any state other than IDLE and FAULT are ignored.
- ERR is 00 in every state except FAULT.

## Timing
- Prescaler: free-running counter 0..TICK_DIV-1. tick=1 for the one cycle in which the count equals TICK_DIV-1. Reset value 0.
- Phase timer: cleared on every state change; increments on tick. The phase exits on the edge where tick=1 and timer=DUR-1.
- With TICK_DIV=1 a phase lasts exactly DUR cycles. In general it lasts between (DUR-1)·TICK_DIV+1 and DUR·TICK_DIV cycles.
- Latency:
  - A start event sampled at edge k puts ST=1 after edge k and ST=2 after edge k+1.
  - Abort conditions sampled at edge k put the actuator at 0 after edge k.
- Reset, including mid-operation: immediately ST=0, AQ=PP=P=BUSY=DONE=0, ERR=00, prescaler=0, timer=0, size=00, a_q=1.
- Widths: timer and durations are 8 bits. The prescaler counter uses $clog2(TICK_DIV)+1 bits; no wrap occurs within a phase.

## Test plan
All scenarios use TICK_DIV=1 and the default durations.
- Normal small cycle: A 0→1 with VL=1, SEL=01, all sensors 1 →
  - ST 1 for 1 cycle, then AQ for 5 cycles, then PP for 2, then P for 3.
  - DONE pulses for 1 cycle, then ST=0.
  - BUSY=1 for 12 cycles total.
- Invalid requests:
  - A edge with VL=0 → ST stays 0.
  - A edge with SEL=00 → ST stays 0.
  - A held high with no new edge → no start.
- Missing powder: SP=0 at CHECK → FAULT, ERR=10, no actuator asserted. Next A edge → ST=0, ERR=00.
- Cup removed: SN dropped at the 4th cycle of a large POUR → P=0 on the next edge, FAULT, ERR=11.
- Simultaneous loss: SR=0 and SN=0 in the same HEAT cycle → ERR=01.
- Reset mid-POUR with A held high:
  - All outputs 0 immediately on RST=0.
  - After release, no new cycle starts until A goes low and then high again.
- Selection change: SEL changed from 11 to 01 during HEAT → POUR still lasts 8 cycles.
